// File: rtl/cvxif_dot4_mac.sv
// CV-X-IF coprocessor: packed int8 dot-product with a 32-bit accumulator, two-stage pipe.
// Build option: define CVXIF_DOT4_MAC_SAT_EN to saturate DOT4 accumulation instead of wrapping.
module cvxif_dot4_mac #(
    parameter int ID_WIDTH = 4,
    parameter int NR_RS    = 2,
    parameter int XLEN     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                busy_o
);

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    typedef enum logic [1:0] {
        OP_DOT4   = 2'd0,
        OP_RDACC  = 2'd1,
        OP_CLRACC = 2'd2
    } op_e;

    if (NR_RS != 2 || XLEN != 32) begin : g_param_check
        $error("cvxif_dot4_mac supports only NR_RS=2 and XLEN=32");
    end

    function automatic logic signed [XLEN-1:0] acc_add(
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
`ifdef CVXIF_DOT4_MAC_SAT_EN
        logic signed [XLEN:0] s;
        s = {a[XLEN-1], a} + {b[XLEN-1], b};
        if (s[XLEN] != s[XLEN-1]) begin
            acc_add = s[XLEN] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
        end else begin
            acc_add = s[XLEN-1:0];
        end
`else
        acc_add = a + b;
`endif
    endfunction

    function automatic logic signed [17:0] sext18(input logic signed [15:0] p);
        sext18 = {{2{p[15]}}, p};
    endfunction

    logic [2:0] funct3;
    logic [4:0] rd_dec;
    logic       dec_ok;
    logic       issue_fire;
    logic       s2_load;
    logic       unused_instr_bits;

    assign funct3            = issue_instr_i[14:12];
    assign rd_dec            = issue_instr_i[11:7];
    assign unused_instr_bits = ^issue_instr_i[24:15];

    always_comb begin
        dec_ok = 1'b0;
        if (issue_instr_i[6:0] == OPC_CUSTOM0 && issue_instr_i[31:25] == 7'd0) begin
            dec_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
    end

    assign issue_accept_o    = dec_ok;
    assign issue_writeback_o = dec_ok && (rd_dec != 5'd0);

    logic vld_p1;
    logic vld_p2;

    // S1 stays occupied only while S2 is blocked by the core.
    assign s2_load       = !vld_p2 || result_ready_i;
    assign issue_ready_o = !vld_p1 || s2_load;
    assign issue_fire    = issue_valid_i && issue_ready_o && dec_ok;

    logic signed [15:0] prod_c [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod_c[i] = $signed(issue_rs1_i[8*i +: 8]) * $signed(issue_rs2_i[8*i +: 8]);
        end
    end

    // ---- stage S1: products and instruction tag ----
    logic signed [15:0]  prod_p1 [4];
    logic [ID_WIDTH-1:0] id_p1;
    logic [4:0]          rd_p1;
    op_e                 op_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
        end else if (issue_ready_o) begin
            vld_p1 <= issue_fire;
        end
    end

    always_ff @(posedge clk_i) begin
        if (issue_fire) begin
            for (int i = 0; i < 4; i++) begin
                prod_p1[i] <= prod_c[i];
            end
            id_p1 <= issue_id_i;
            rd_p1 <= rd_dec;
            op_p1 <= op_e'(funct3[1:0]);
        end
    end

    logic signed [17:0]     sum18;
    logic signed [XLEN-1:0] sum_ext;
    logic signed [XLEN-1:0] acc;
    logic signed [XLEN-1:0] acc_nxt;
    logic signed [XLEN-1:0] res_nxt;

    assign sum18   = sext18(prod_p1[0]) + sext18(prod_p1[1]) + sext18(prod_p1[2]) + sext18(prod_p1[3]);
    assign sum_ext = {{(XLEN-18){sum18[17]}}, sum18};

    always_comb begin
        acc_nxt = acc;
        res_nxt = acc;
        case (op_p1)
            OP_DOT4: begin
                acc_nxt = acc_add(acc, sum_ext);
                res_nxt = acc_nxt;
            end
            OP_CLRACC: acc_nxt = '0;
            default: ;
        endcase
    end

    // ---- stage S2: accumulate; doubles as the result register ----
    logic [ID_WIDTH-1:0]    id_p2;
    logic [4:0]             rd_p2;
    logic signed [XLEN-1:0] data_p2;
    logic                   we_p2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2  <= 1'b0;
            acc     <= '0;
            id_p2   <= '0;
            rd_p2   <= '0;
            data_p2 <= '0;
            we_p2   <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                acc     <= acc_nxt;
                id_p2   <= id_p1;
                rd_p2   <= rd_p1;
                data_p2 <= res_nxt;
                we_p2   <= (rd_p1 != 5'd0);
            end
        end
    end

    assign result_valid_o = vld_p2;
    assign result_id_o    = id_p2;
    assign result_rd_o    = rd_p2;
    assign result_data_o  = data_p2;
    assign result_we_o    = vld_p2 && we_p2;
    assign busy_o         = vld_p1 || vld_p2;

endmodule
